// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB elastic stage: entry layout and occupancy states.
// Default widths here match the stage's parameter defaults.
package mem_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int STAT_W_DEF = 32;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] ram_data;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [REG_AW_DEF-1:0] rd;
    logic                  regwrite;
    logic                  memtoreg;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/mem_wb_elastic_sat_counter.sv
// Saturating up-counter used for the MEM->WB stall/bubble statistics.
module sat_counter #(
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              inc,
  output logic [STAT_W-1:0] cnt
);

  logic [STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM->WB pipeline stage: head + skid register, registered in_ready, flush, rd==0 write suppression.
// Optional statistics counters are built only when MEM_WB_STATS_EN is defined.
module mem_wb_elastic
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] rd_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              regwrite_out,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
);

  // Local entry type so overridden widths stay consistent
  typedef struct packed {
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] alu_res;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memtoreg;
  } entry_t;

  wb_state_t state_q, state_d;
  entry_t    head_q, head_d;
  entry_t    skid_q, skid_d;
  logic      in_ready_q, in_ready_d;
  entry_t    in_entry;
  logic      accept, pop;

  assign in_entry = {ram_data_in, alu_res_in, rd_in, regwrite_in, memtoreg_in};
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_d  = in_entry;
          state_d = ONE;
        end
        ONE: begin
          if (accept && pop) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    // ready is decided from next occupancy so it never depends on this cycle's out_ready
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign rd_out       = head_q.rd;
  assign wb_data      = head_q.memtoreg ? head_q.ram_data : head_q.alu_res;
  assign regwrite_out = out_valid & head_q.regwrite & (|head_q.rd);

`ifdef MEM_WB_STATS_EN
  sat_counter #(.STAT_W(STAT_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (out_valid & ~out_ready),
    .cnt     (stall_cnt)
  );

  sat_counter #(.STAT_W(STAT_W)) u_bubble_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (~out_valid),
    .cnt     (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Self-checking bench for mem_wb_elastic: vector table, hand sequences and a queue reference model.
// Statistics checks follow MEM_WB_STATS_EN.
module tb_mem_wb_elastic;
  import mem_wb_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        flush, in_valid, in_ready;
  logic [31:0] ram_data_in, alu_res_in;
  logic [4:0]  rd_in;
  logic        regwrite_in, memtoreg_in;
  logic        out_valid, out_ready;
  logic [4:0]  rd_out;
  logic [31:0] wb_data;
  logic        regwrite_out;
  logic [31:0] stall_cnt, bubble_cnt;

  int checks = 0;
  int failures = 0;

  mem_wb_elastic dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ram_data_in  (ram_data_in),
    .alu_res_in   (alu_res_in),
    .rd_in        (rd_in),
    .regwrite_in  (regwrite_in),
    .memtoreg_in  (memtoreg_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rd_out       (rd_out),
    .wb_data      (wb_data),
    .regwrite_out (regwrite_out),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    wb_entry_t   e;
    logic [31:0] exp_wb;
    logic        exp_rw;
  } vec_t;

  vec_t      vecs[6];
  wb_entry_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input wb_entry_t e);
    ram_data_in = e.ram_data;
    alu_res_in  = e.alu_res;
    rd_in       = e.rd;
    regwrite_in = e.regwrite;
    memtoreg_in = e.memtoreg;
  endtask

  function automatic wb_entry_t mk(input logic [31:0] ram, input logic [31:0] alu,
                                   input logic [4:0] rd, input logic rw, input logic m2r);
    wb_entry_t e;
    e.ram_data = ram; e.alu_res = alu; e.rd = rd; e.regwrite = rw; e.memtoreg = m2r;
    return e;
  endfunction

  function automatic logic [31:0] wbsel(input wb_entry_t e);
    return e.memtoreg ? e.ram_data : e.alu_res;
  endfunction

  initial begin
    wb_entry_t ea, eb, ec, ex, ey, ez, re;
    int stall_e, bubble_e;
    logic pop_m, acc_m;

    vecs[0] = '{mk(32'h0, 32'h10, 5'd3, 1'b1, 1'b0), 32'h10, 1'b1};
    vecs[1] = '{mk(32'hDEADBEEF, 32'h4, 5'd7, 1'b1, 1'b1), 32'hDEADBEEF, 1'b1};
    vecs[2] = '{mk(32'h1234, 32'h55AA, 5'd0, 1'b1, 1'b0), 32'h55AA, 1'b0};
    vecs[3] = '{mk(32'hCAFE0000, 32'h9, 5'd31, 1'b0, 1'b1), 32'hCAFE0000, 1'b0};
    vecs[4] = '{mk(32'hFFFFFFFF, 32'h0, 5'd1, 1'b1, 1'b1), 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{mk(32'h77, 32'hFFFF0001, 5'd16, 1'b1, 1'b0), 32'hFFFF0001, 1'b1};

    RESET_N = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_regwrite", regwrite_out, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_bubble", bubble_cnt, 0);
    step();
    RESET_N = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);

    // streaming with out_ready high: every entry appears one cycle after being presented
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      drive(vecs[i].e);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_wb", i), wb_data, vecs[i].exp_wb);
      chk($sformatf("vec%0d_rd", i), rd_out, vecs[i].e.rd);
      chk($sformatf("vec%0d_rw", i), regwrite_out, vecs[i].exp_rw);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_rw", regwrite_out, 0);

    // back-pressure: A,B held, C waits, then all three in order
    ea = mk(32'hA0, 32'hA1, 5'd10, 1'b1, 1'b0);
    eb = mk(32'hB0, 32'hB1, 5'd11, 1'b1, 1'b1);
    ec = mk(32'hC0, 32'hC1, 5'd12, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; drive(ea); step();
    chk("bp_a_ready", in_ready, 1);
    drive(eb); step();
    chk("bp_full_ready", in_ready, 0);
    drive(ec); step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_a", wb_data, 32'hA1);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1; step();
    chk("bp_out_b", wb_data, 32'hB0);
    chk("bp_out_b_rd", rd_out, 11);
    step();
    chk("bp_out_c", wb_data, 32'hC1);
    chk("bp_out_c_rd", rd_out, 12);
    in_valid = 1'b0; step();
    chk("bp_empty", out_valid, 0);

    // flush from FULL with a new entry presented
    ex = mk(32'h0, 32'h1111, 5'd4, 1'b1, 1'b0);
    ey = mk(32'h0, 32'h2222, 5'd5, 1'b1, 1'b0);
    ez = mk(32'h0, 32'h3333, 5'd6, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; drive(ex); step();
    drive(ey); step();
    chk("fl_full_ready", in_ready, 0);
    flush = 1'b1; drive(ez); step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_rw", regwrite_out, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_keep_data", wb_data, 32'h1111);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_gone%0d", i), out_valid, 0);
    end

    // statistics and asynchronous reset mid-run
    RESET_N = 1'b0; out_ready = 1'b0; step();
    RESET_N = 1'b1; step();
    in_valid = 1'b1; drive(ex); step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
`ifdef MEM_WB_STATS_EN
    chk("st_stall5", stall_cnt, 5);
    chk("st_bubble2", bubble_cnt, 2);
`else
    chk("st_stall_tied", stall_cnt, 0);
    chk("st_bubble_tied", bubble_cnt, 0);
`endif
    chk("st_head_valid", out_valid, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_bubble", bubble_cnt, 0);
    chk("ar_rw", regwrite_out, 0);
    step();
    RESET_N = 1'b1;

    // randomized traffic against a queue model
    mq.delete();
    stall_e = 0; bubble_e = 0;
    step();
    bubble_e = 1;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      re = mk($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) re.rd = 5'd0;
      drive(re);
      chk("rnd_valid", out_valid, mq.size() != 0);
      chk("rnd_ready", in_ready, mq.size() < 2);
      if (mq.size() != 0) begin
        chk("rnd_wb", wb_data, wbsel(mq[0]));
        chk("rnd_rd", rd_out, mq[0].rd);
        chk("rnd_rw", regwrite_out, mq[0].regwrite && (mq[0].rd != 0));
      end else begin
        chk("rnd_rw_empty", regwrite_out, 0);
      end
`ifdef MEM_WB_STATS_EN
      chk("rnd_stall", stall_cnt, stall_e);
      chk("rnd_bubble", bubble_cnt, bubble_e);
`endif
      if (mq.size() == 0) bubble_e++;
      else if (!out_ready) stall_e++;
      pop_m = (mq.size() != 0) && out_ready;
      acc_m = in_valid && (mq.size() < 2);
      if (flush) mq.delete();
      else begin
        if (pop_m) void'(mq.pop_front());
        if (acc_m) mq.push_back(re);
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
